// File: rtl/avg_pool_pkg.sv
// Shared defaults and FSM state encoding for the 2x2/stride-2 average-pooling sequencer.
package avg_pool_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IN_H   = 28;
  localparam int DEF_IN_W   = 28;
  localparam int DEF_OUT_H  = DEF_IN_H / 2;
  localparam int DEF_OUT_W  = DEF_IN_W / 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

endpackage

// File: rtl/avg4_acc.sv
// Collects four returning beats of a pooling window and emits their floored average one cycle later.
module avg4_acc
  import avg_pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_vld,
  input  logic [DATA_W-1:0] beat_data,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data
);

  logic [1:0]               beat;
  logic signed [DATA_W+1:0] acc;
  logic signed [DATA_W+1:0] sum;
  logic [DATA_W-1:0]        avg;

  // Beat 0 restarts the window; two guard bits make a four-term sum of extremes fit.
  always_comb begin
    sum = {{2{beat_data[DATA_W-1]}}, beat_data} + ((beat == 2'd0) ? '0 : acc);
    avg = DATA_W'(sum >>> 2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat    <= 2'd0;
      acc     <= '0;
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (beat_vld) begin
        acc  <= sum;
        beat <= beat + 2'd1;
        if (beat == 2'd3) begin
          wr_en   <= 1'b1;
          wr_data <= avg;
        end
      end
    end
  end

endmodule

// File: rtl/avg_pool_ctrl.sv
// Streams one feature map out of the input RAM in window order and writes 2x2 averages to the output RAM.
module avg_pool_ctrl
  import avg_pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IN_H   = DEF_IN_H,
  parameter int IN_W   = DEF_IN_W,
  parameter int RD_LAT = 1,
  parameter int IN_AW  = $clog2(DEF_IN_H * DEF_IN_W),
  parameter int OUT_AW = $clog2(DEF_OUT_H * DEF_OUT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              in_rd_en,
  output logic [IN_AW-1:0]  in_rd_addr,
  input  logic [DATA_W-1:0] in_rd_data,
  output logic              out_wr_en,
  output logic [OUT_AW-1:0] out_wr_addr,
  output logic [DATA_W-1:0] out_wr_data
);

  localparam int OUT_H = IN_H / 2;
  localparam int OUT_W = IN_W / 2;
  localparam int OUT_N = OUT_H * OUT_W;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  state_t            state;
  logic [1:0]        beat;
  logic [CW-1:0]     ocol;
  logic [RW-1:0]     orow;
  logic [1:0]        nxt_beat;
  logic [CW-1:0]     nxt_ocol;
  logic [RW-1:0]     nxt_orow;
  logic              last_read;
  logic [RD_LAT-1:0] vld_sr;
  logic              acc_wr_en;
  logic [DATA_W-1:0] acc_wr_data;

  function automatic logic [IN_AW-1:0] addr_of(input logic [RW-1:0] r,
                                               input logic [CW-1:0] c,
                                               input logic [1:0]    b);
    return IN_AW'((2 * int'(r) + int'(b[1])) * IN_W + 2 * int'(c) + int'(b[0]));
  endfunction

  // Beat index walks the window; output column/row advance once per completed window.
  always_comb begin
    nxt_beat  = beat + 2'd1;
    nxt_ocol  = ocol;
    nxt_orow  = orow;
    last_read = (beat == 2'd3) && (ocol == CW'(OUT_W - 1)) && (orow == RW'(OUT_H - 1));
    if (beat == 2'd3) begin
      if (ocol == CW'(OUT_W - 1)) begin
        nxt_ocol = '0;
        nxt_orow = orow + RW'(1);
      end else begin
        nxt_ocol = ocol + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_rd_en    <= 1'b0;
      in_rd_addr  <= '0;
      beat        <= 2'd0;
      ocol        <= '0;
      orow        <= '0;
      out_wr_addr <= '0;
    end else begin
      done <= 1'b0;
      if (acc_wr_en) out_wr_addr <= out_wr_addr + OUT_AW'(1);
      case (state)
        IDLE, FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            state       <= READ;
            busy        <= 1'b1;
            in_rd_en    <= 1'b1;
            in_rd_addr  <= '0;
            beat        <= 2'd0;
            ocol        <= '0;
            orow        <= '0;
            out_wr_addr <= '0;
          end
        end
        READ: begin
          if (last_read) begin
            in_rd_en <= 1'b0;
            state    <= DRAIN;
          end else begin
            beat       <= nxt_beat;
            ocol       <= nxt_ocol;
            orow       <= nxt_orow;
            in_rd_addr <= addr_of(nxt_orow, nxt_ocol, nxt_beat);
          end
        end
        DRAIN: begin
          if (acc_wr_en && (out_wr_addr == OUT_AW'(OUT_N - 1))) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delays each read strobe by the RAM latency so the accumulator samples only real returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  avg4_acc #(
    .DATA_W (DATA_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .beat_vld  (vld_sr[RD_LAT-1]),
    .beat_data (in_rd_data),
    .wr_en     (acc_wr_en),
    .wr_data   (acc_wr_data)
  );

  assign out_wr_en   = acc_wr_en;
  assign out_wr_data = acc_wr_data;

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// Self-checking bench: two sequencers (read latency 1 and 3) against a RAM model and an arithmetic pooling reference.
module tb_avg_pool_ctrl;

  localparam int NPIX = 784;
  localparam int NOUT = 196;

  logic        clk;
  logic        rst;
  logic        start    [2];
  logic        busy     [2];
  logic        done     [2];
  logic        rd_en    [2];
  logic [9:0]  rd_addr  [2];
  logic [15:0] rd_data  [2];
  logic        wr_en    [2];
  logic [7:0]  wr_addr  [2];
  logic [15:0] wr_data  [2];

  logic [15:0] img [NPIX];
  logic [15:0] out_mem [2][NOUT];
  logic [15:0] pipe0;
  logic [15:0] pipe1 [3];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int fstart[2], rd_cnt[2], wr_cnt[2], err[2], done_tot[2], done_rel[2];
  int snap_wr[2], snap_rd[2], snap_err[2], snap_mism[2];

  avg_pool_ctrl #(.RD_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .in_rd_en(rd_en[0]), .in_rd_addr(rd_addr[0]), .in_rd_data(rd_data[0]),
    .out_wr_en(wr_en[0]), .out_wr_addr(wr_addr[0]), .out_wr_data(wr_data[0])
  );

  avg_pool_ctrl #(.RD_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .in_rd_en(rd_en[1]), .in_rd_addr(rd_addr[1]), .in_rd_data(rd_data[1]),
    .out_wr_en(wr_en[1]), .out_wr_addr(wr_addr[1]), .out_wr_data(wr_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input RAMs: junk on the data bus whenever no read is in flight.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    pipe0    <= rd_en[0] ? img[rd_addr[0]] : 16'($urandom);
    pipe1[0] <= rd_en[1] ? img[rd_addr[1]] : 16'($urandom);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rd_data[0] = pipe0;
  assign rd_data[1] = pipe1[2];

  function automatic int exp_rd_addr(int i);
    int k = i / 4;
    int b = i % 4;
    return (2 * (k / 14) + b / 2) * 28 + 2 * (k % 14) + b % 2;
  endfunction

  function automatic int ref_avg(int k);
    int r = k / 14;
    int c = k % 14;
    int s = 0;
    int q;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        s += int'($signed(img[(2 * r + dr) * 28 + 2 * c + dc]));
    q = s / 4;
    if ((s % 4 != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int count_mism(int g);
    int n = 0;
    logic [15:0] e;
    for (int k = 0; k < NOUT; k++) begin
      e = 16'(ref_avg(k));
      if (out_mem[g][k] !== e) n++;
    end
    return n;
  endfunction

  // Tracks one frame per sequencer: read order/timing, write order/timing, handshake sanity.
  always @(negedge clk) begin
    int rel;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        rd_cnt[g] = 0;
        wr_cnt[g] = 0;
        err[g]    = 0;
      end else begin
        rel = cyc - fstart[g];
        if (rd_en[g]) begin
          if (int'(rd_addr[g]) != exp_rd_addr(rd_cnt[g]) || rel != rd_cnt[g] + 1 || !busy[g]) err[g]++;
          rd_cnt[g]++;
        end
        if (wr_en[g]) begin
          if (int'(wr_addr[g]) != wr_cnt[g] || rel != 4 * wr_cnt[g] + 5 + ((g == 0) ? 1 : 3) || !busy[g]) err[g]++;
          if (int'(wr_addr[g]) < NOUT) out_mem[g][int'(wr_addr[g])] = wr_data[g];
          wr_cnt[g]++;
        end
        if (done[g]) begin
          if (busy[g]) err[g]++;
          done_tot[g]++;
          done_rel[g]  = rel;
          snap_wr[g]   = wr_cnt[g];
          snap_rd[g]   = rd_cnt[g];
          snap_err[g]  = err[g];
          snap_mism[g] = count_mism(g);
        end
        if (start[g] && !busy[g]) begin
          fstart[g] = cyc;
          rd_cnt[g] = 0;
          wr_cnt[g] = 0;
          err[g]    = 0;
          for (int k = 0; k < NOUT; k++) out_mem[g][k] = 'x;
        end
      end
    end
  end

  task automatic check_output(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int g);
    @(posedge clk); #1;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int target, input string tag);
    int n = 0;
    while (done_tot[g] < target && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check_output({tag, "_done_seen"}, int'(done_tot[g] >= target), 1);
  endtask

  task automatic check_frame(input int g, input string tag, input int exp_done);
    check_output({tag, "_done_cycle"}, done_rel[g], exp_done);
    check_output({tag, "_writes"}, snap_wr[g], NOUT);
    check_output({tag, "_reads"}, snap_rd[g], NPIX);
    check_output({tag, "_seq_errs"}, snap_err[g], 0);
    check_output({tag, "_data_errs"}, snap_mism[g], 0);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) img[i] = 16'($urandom);
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < NPIX; i++) img[i] = v;
  endtask

  task automatic set_window(input int k, input int a, input int b, input int c, input int d);
    img[2 * k]      = 16'(a);
    img[2 * k + 1]  = 16'(b);
    img[28 + 2 * k] = 16'(c);
    img[29 + 2 * k] = 16'(d);
  endtask

  initial begin
    int d0;
    int d1;
    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    for (int i = 0; i < NPIX; i++) img[i] = 16'(i);

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", int'(busy[0]), 0);
    check_output("rst_done", int'(done[0]), 0);
    check_output("rst_rd_en", int'(rd_en[0]), 0);
    check_output("rst_rd_addr", int'(rd_addr[0]), 0);
    check_output("rst_wr_en", int'(wr_en[0]), 0);
    check_output("rst_wr_addr", int'(wr_addr[0]), 0);
    check_output("rst_wr_data", int'(wr_data[0]), 0);
    check_output("rst_busy_lat3", int'(busy[1]), 0);
    rst = 1'b0;

    $display("[TB] ramp frame");
    apply_stimulus(0);
    wait_done(0, 1, "ramp");
    check_frame(0, "ramp", 787);
    check_output("ramp_out00", int'(out_mem[0][0]), 14);
    check_output("ramp_out1313", int'(out_mem[0][195]), 768);

    $display("[TB] signed windows");
    fill_rand();
    set_window(0, -1, 0, 0, 0);
    set_window(1, -3, -3, -3, -3);
    set_window(2, 5, 6, 6, 6);
    apply_stimulus(0);
    wait_done(0, 2, "signed");
    check_frame(0, "signed", 787);
    check_output("signed_w0", int'(out_mem[0][0]), 16'hFFFF);
    check_output("signed_w1", int'(out_mem[0][1]), 16'hFFFD);
    check_output("signed_w2", int'(out_mem[0][2]), 5);

    $display("[TB] saturating extremes");
    fill_const(16'h7FFF);
    apply_stimulus(0);
    wait_done(0, 3, "maxpos");
    check_frame(0, "maxpos", 787);
    check_output("maxpos_out", int'(out_mem[0][100]), 16'h7FFF);
    fill_const(16'h8000);
    apply_stimulus(0);
    wait_done(0, 4, "maxneg");
    check_frame(0, "maxneg", 787);
    check_output("maxneg_out", int'(out_mem[0][57]), 16'h8000);

    $display("[TB] start while busy");
    fill_rand();
    d0 = done_tot[0];
    apply_stimulus(0);
    repeat (9) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (389) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, d0 + 1, "ignore");
    check_frame(0, "ignore", 787);
    repeat (20) @(posedge clk);
    #1;
    check_output("ignore_one_done", done_tot[0], d0 + 1);
    check_output("ignore_total_writes", wr_cnt[0], NOUT);

    $display("[TB] reset mid-frame");
    fill_rand();
    d0 = done_tot[0];
    apply_stimulus(0);
    repeat (299) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_output("abort_rd_en", int'(rd_en[0]), 0);
    check_output("abort_wr_en", int'(wr_en[0]), 0);
    check_output("abort_busy", int'(busy[0]), 0);
    check_output("abort_done", int'(done[0]), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_output("abort_no_done", done_tot[0], d0);
    fill_rand();
    apply_stimulus(0);
    wait_done(0, d0 + 1, "rerun");
    check_frame(0, "rerun", 787);

    $display("[TB] back-to-back frames, read latency 3");
    fill_rand();
    d1 = done_tot[1];
    @(posedge clk);
    #1 start[1] = 1'b1;
    wait_done(1, d1 + 1, "b2b1");
    check_frame(1, "b2b1", 789);
    wait_done(1, d1 + 2, "b2b2");
    check_frame(1, "b2b2", 789);
    @(posedge clk);
    #1 start[1] = 1'b0;
    wait_done(1, d1 + 3, "b2b3");
    check_frame(1, "b2b3", 789);
    repeat (10) @(posedge clk);
    #1;
    check_output("b2b_done_count", done_tot[1], d1 + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
